// File: rtl/qbus_slave_sequencer.sv
// QBUS slave reply sequencer: claims a bus cycle for one of NDEV register
// blocks and times TRPLY. Optional reply watchdog: QSLAVE_TIMEOUT_EN.
module qbus_slave_sequencer #(
    parameter int NDEV      = 4,
    parameter int REPLY_DLY = 2
) (
    input  logic                 qclk,
    input  logic                 reset_n,
    input  logic                 RSYNC,
    input  logic                 RDIN,
    input  logic                 RDOUT,
    input  logic [NDEV-1:0]      dev_match,
    input  logic [16*NDEV-1:0]   dev_tdl,
    output logic [15:0]          TDL,
    output logic                 TDL_oe,
    output logic                 TRPLY,
    output logic [NDEV-1:0]      dev_write_pulse,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int SW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [2:0] {
        IDLE, ADDR, READ, RREPLY, WRITE, WREPLY, UNCLAIMED
    } state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   sel, sel_nx, match_idx;
    logic [3:0]      cnt, cnt_nx;
    logic            rsync_q;
    logic            rise;
    logic            tmo_hit;
    logic [15:0]     tdl_d;
    logic            oe_d, trply_d, busy_d;
    logic [NDEV-1:0] wp_d;

    // rsync_q resets high so a strobe already high at reset release is ignored
    assign rise = RSYNC & ~rsync_q;

    // Lowest-index claiming device wins
    always_comb begin
        match_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--)
            if (dev_match[i]) match_idx = SW'(i);
    end

`ifdef QSLAVE_TIMEOUT_EN
    logic [7:0] tmo;
    logic       tmo_fire;

    assign tmo_hit  = (tmo == 8'd254);
    assign tmo_fire = tmo_hit && RSYNC &&
                      ((state == RREPLY && RDIN) ||
                       (state == WREPLY && RDOUT));

    // Reply watchdog: counts cycles spent holding TRPLY in one reply phase
    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            tmo         <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
            if ((state == RREPLY || state == WREPLY) && state_nx == state)
                tmo <= tmo + 8'd1;
            else
                tmo <= 8'd0;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State, device select, delay counter and strobe history
    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sel     <= '0;
            cnt     <= 4'd0;
            rsync_q <= 1'b1;
        end else begin
            state   <= state_nx;
            sel     <= sel_nx;
            cnt     <= cnt_nx;
            rsync_q <= RSYNC;
        end
    end

    // Next-state: RSYNC low aborts every claimed phase
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = 4'd0;
                if (rise) begin
                    if (|dev_match) begin
                        sel_nx   = match_idx;
                        state_nx = ADDR;
                    end else begin
                        state_nx = UNCLAIMED;
                    end
                end
            end
            UNCLAIMED: begin
                cnt_nx = 4'd0;
                if (!RSYNC) state_nx = IDLE;
            end
            ADDR: begin
                if (!RSYNC) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (RDIN) begin
                    state_nx = READ;
                    cnt_nx   = 4'(REPLY_DLY);
                end else if (RDOUT) begin
                    state_nx = WRITE;
                    cnt_nx   = 4'(REPLY_DLY);
                end
            end
            READ, WRITE: begin
                if (!RSYNC) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx = (state == READ) ? RREPLY : WREPLY;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RREPLY, WREPLY: begin
                cnt_nx = 4'd0;
                if (!RSYNC)
                    state_nx = IDLE;
                else if (!((state == RREPLY) ? RDIN : RDOUT))
                    state_nx = ADDR;
                else if (tmo_hit)
                    state_nx = UNCLAIMED;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Output values for the coming state, registered below
    always_comb begin
        busy_d  = (state_nx != IDLE);
        oe_d    = (state_nx == READ) || (state_nx == RREPLY);
        trply_d = (state_nx == RREPLY) || (state_nx == WREPLY);
        tdl_d   = 16'd0;
        if (oe_d) tdl_d = dev_tdl[16*int'(sel_nx) +: 16];
        wp_d = '0;
        if (state == ADDR && state_nx == WRITE) wp_d[sel] = 1'b1;
    end

    // Registered bus-side outputs
    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            TDL             <= 16'd0;
            TDL_oe          <= 1'b0;
            TRPLY           <= 1'b0;
            dev_write_pulse <= '0;
            busy            <= 1'b0;
        end else begin
            TDL             <= tdl_d;
            TDL_oe          <= oe_d;
            TRPLY           <= trply_d;
            dev_write_pulse <= wp_d;
            busy            <= busy_d;
        end
    end

endmodule

// File: tb/tb_qbus_slave_sequencer.sv
// Self-checking bench for qbus_slave_sequencer (NDEV=4, REPLY_DLY=2).
// Timeout scenario runs only when QSLAVE_TIMEOUT_EN is defined.
module tb_qbus_slave_sequencer;

    localparam int NDEV = 4;
    localparam int DLY  = 2;

    logic              qclk = 1'b0;
    logic              reset_n;
    logic              RSYNC, RDIN, RDOUT;
    logic [NDEV-1:0]   dev_match;
    logic [16*NDEV-1:0] dev_tdl;
    logic [15:0]       TDL;
    logic              TDL_oe, TRPLY, busy, timeout_err;
    logic [NDEV-1:0]   dev_write_pulse;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0]     rd_q[$];
    logic [NDEV-1:0] wr_q[$];

    qbus_slave_sequencer #(.NDEV(NDEV), .REPLY_DLY(DLY)) dut (
        .qclk(qclk), .reset_n(reset_n),
        .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
        .dev_match(dev_match), .dev_tdl(dev_tdl),
        .TDL(TDL), .TDL_oe(TDL_oe), .TRPLY(TRPLY),
        .dev_write_pulse(dev_write_pulse),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #25 qclk = ~qclk;

    // Inputs change and outputs are sampled at the falling edge
    task automatic tick();
        @(negedge qclk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; RSYNC = 0; RDIN = 0; RDOUT = 0;
        dev_match = '0; dev_tdl = '0;
        tick(); tick();
        vectors++;
        if ({TRPLY, TDL_oe, busy, timeout_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctl got %b want 0000",
                     {TRPLY, TDL_oe, busy, timeout_err});
        end
        vectors++;
        if (TDL !== 16'd0 || dev_write_pulse !== '0) begin
            miscompares++;
            $display("FAIL reset_data got TDL=%h wp=%b want 0/0",
                     TDL, dev_write_pulse);
        end
        reset_n = 1'b1;
        tick(); tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_read();
        int n;
        logic [15:0] e;
        dev_match = 4'b0100;
        dev_tdl = {16'o1111, 16'o0777, 16'o2222, 16'o3333};
        RSYNC = 1'b1;
        tick();
        dev_match = 4'b0001;
        RDIN = 1'b1;
        rd_q.push_back(16'o0777);
        tick();
        vectors++;
        if (TDL_oe !== 1'b1 || TRPLY !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_read_phase got oe=%b rply=%b want 1/0",
                     TDL_oe, TRPLY);
        end
        n = 0;
        do begin tick(); n++; end while (!TRPLY && n < 40);
        vectors++;
        if (n !== DLY + 1) begin
            miscompares++;
            $display("FAIL rd_latency got %0d want %0d", n, DLY + 1);
        end
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        vectors++;
        if (TDL !== e || TDL_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_data got %o oe=%b want %o oe=1", TDL, TDL_oe, e);
        end
        RDIN = 1'b0;
        tick();
        vectors++;
        if (TRPLY !== 1'b0 || TDL_oe !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_release got rply=%b oe=%b busy=%b want 0/0/1",
                     TRPLY, TDL_oe, busy);
        end
        RSYNC = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_end busy got %b want 0", busy);
        end
    endtask

    task automatic test_write();
        int n, extra;
        logic [NDEV-1:0] e;
        dev_match = 4'b0110;
        RSYNC = 1'b1;
        tick();
        RDOUT = 1'b1;
        wr_q.push_back(4'b0010);
        tick();
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 'x;
        vectors++;
        if (dev_write_pulse !== e) begin
            miscompares++;
            $display("FAIL wr_pulse got %b want %b", dev_write_pulse, e);
        end
        n = 0; extra = 0;
        do begin
            tick(); n++;
            if (dev_write_pulse !== '0) extra++;
        end while (!TRPLY && n < 40);
        vectors++;
        if (n !== DLY + 1) begin
            miscompares++;
            $display("FAIL wr_latency got %0d want %0d", n, DLY + 1);
        end
        vectors++;
        if (extra !== 0 || TDL_oe !== 1'b0 || TDL !== 16'd0) begin
            miscompares++;
            $display("FAIL wr_side got extra=%0d oe=%b TDL=%h want 0/0/0",
                     extra, TDL_oe, TDL);
        end
        RDOUT = 1'b0;
        tick();
        vectors++;
        if (TRPLY !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_release got %b want 0", TRPLY);
        end
        RSYNC = 1'b0;
        tick();
    endtask

    task automatic test_unclaimed();
        int bad;
        dev_match = 4'b0000;
        RSYNC = 1'b1; RDIN = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (TRPLY || TDL_oe || dev_write_pulse != '0 || timeout_err) bad++;
        end
        vectors++;
        if (bad !== 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL unclaimed got bad=%0d busy=%b want 0/1", bad, busy);
        end
        RSYNC = 1'b0; RDIN = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL unclaimed_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_datio();
        int n, extra;
        logic [15:0] e;
        logic [NDEV-1:0] w;
        dev_match = 4'b1000;
        dev_tdl[48 +: 16] = 16'hA5C3;
        RSYNC = 1'b1;
        tick();
        dev_match = 4'b0001;
        RDIN = 1'b1;
        tick();
        dev_tdl[48 +: 16] = 16'h5A3C;
        rd_q.push_back(16'h5A3C);
        n = 0;
        do begin tick(); n++; end while (!TRPLY && n < 40);
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        vectors++;
        if (TRPLY !== 1'b1 || TDL !== e) begin
            miscompares++;
            $display("FAIL datio_rd got rply=%b TDL=%h want 1/%h", TRPLY, TDL, e);
        end
        RDIN = 1'b0;
        tick();
        RDOUT = 1'b1;
        wr_q.push_back(4'b1000);
        tick();
        w = (wr_q.size() != 0) ? wr_q.pop_front() : 'x;
        vectors++;
        if (dev_write_pulse !== w) begin
            miscompares++;
            $display("FAIL datio_wr got %b want %b", dev_write_pulse, w);
        end
        n = 0; extra = 0;
        do begin
            tick(); n++;
            if (dev_write_pulse !== '0) extra++;
        end while (!TRPLY && n < 40);
        vectors++;
        if (TRPLY !== 1'b1 || extra !== 0) begin
            miscompares++;
            $display("FAIL datio_wreply got rply=%b extra=%0d want 1/0",
                     TRPLY, extra);
        end
        RDOUT = 1'b0;
        tick();
        RDIN = 1'b1;
        tick();
        RSYNC = 1'b0; RDIN = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || TRPLY !== 1'b0 || TDL_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL datio_abort got busy=%b rply=%b oe=%b want 0/0/0",
                     busy, TRPLY, TDL_oe);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        dev_match = 4'b0001;
        RSYNC = 1'b1;
        tick();
        RDOUT = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!TRPLY && n < 40);
        #5 reset_n = 1'b0;
        #1;
        vectors++;
        if ({TRPLY, TDL_oe, busy, dev_write_pulse} !== '0) begin
            miscompares++;
            $display("FAIL reset_async got rply=%b oe=%b busy=%b wp=%b want 0",
                     TRPLY, TDL_oe, busy, dev_write_pulse);
        end
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stale_rsync busy got %b want 0", busy);
        end
        RSYNC = 1'b0; RDOUT = 1'b0;
        tick();
        RSYNC = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rearm busy got %b want 1", busy);
        end
        RSYNC = 1'b0;
        tick();
    endtask

`ifdef QSLAVE_TIMEOUT_EN
    task automatic test_timeout();
        int n, tn;
        dev_match = 4'b0010;
        RSYNC = 1'b1;
        tick();
        RDIN = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!TRPLY && n < 40);
        n = 0; tn = 0;
        do begin
            tick(); n++;
            if (timeout_err) tn = n;
        end while (TRPLY && n < 300);
        vectors++;
        if (n !== 255 || tn !== 255 || TDL_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout got drop=%0d err=%0d oe=%b want 255/255/0",
                     n, tn, TDL_oe);
        end
        tick();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_after got err=%b busy=%b want 0/1",
                     timeout_err, busy);
        end
        RSYNC = 1'b0; RDIN = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unclaimed();
        test_datio();
        test_reset_mid();
`ifdef QSLAVE_TIMEOUT_EN
        test_timeout();
`endif
        vectors++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got rd=%0d wr=%0d want 0/0",
                     rd_q.size(), wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
